// File: rtl/dr_ctrl_decoder_sync.sv
// Clocked dual-rail instruction decoder: settle filter, registered hold/return-to-NULL, sticky errors.
// Optional instruction counter when DR_CTRL_STATS_EN is defined.
module dr_ctrl_decoder_sync #(
   parameter int FW     = 2,
   parameter int NCH    = 3,
   parameter int SETTLE = 1,
   parameter int TMO    = 16,
   parameter int CW     = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [2+3*FW-1:0]   i_in_t,
   input  logic [2+3*FW-1:0]   i_in_f,
   output logic                o_in_ack,
   input  logic                i_out_ack,
   output logic [NCH*FW-1:0]   o_cw_t,
   output logic [NCH*FW-1:0]   o_cw_f,
   output logic [NCH-1:0]      o_inv_t,
   output logic [NCH-1:0]      o_inv_f,
   output logic                o_mr_t,
   output logic                o_mr_f,
   output logic                o_err_conflict,
   output logic                o_err_timeout,
   input  logic                i_err_clr
`ifdef DR_CTRL_STATS_EN
   ,output logic [CW-1:0]      o_instr_cnt
`endif
);

   localparam int IW  = 2 + 3*FW;
   localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int TCW = $clog2(TMO + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DRIVE} state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [IW-1:0]      r_snap_t, r_snap_f;
   logic [SCW-1:0]     r_set_cnt;
   logic [TCW-1:0]     r_tmo_cnt;
   logic [NCH*FW-1:0]  r_cw_t, r_cw_f;
   logic [NCH-1:0]     r_inv_t, r_inv_f;
   logic               r_mr_t, r_mr_f, r_in_ack, r_nop;
   logic               r_err_conflict, r_err_timeout;

   logic               w_complete, w_null, w_conflict, w_partial, w_same, w_tmo_hit;
   logic               w_capture, w_settle_inc, w_decode, w_release;
   logic [1:0]         w_mode;
   logic               w_m10, w_m01, w_m11;
   logic [FW-1:0]      w_a, w_b, w_c;
   logic [NCH*FW-1:0]  w_dec_cw_t, w_dec_cw_f;
   logic [NCH-1:0]     w_dec_inv_t, w_dec_inv_f;

   assign w_complete = &(i_in_t ^ i_in_f);
   assign w_null     = ~|(i_in_t | i_in_f);
   assign w_conflict = |(i_in_t & i_in_f);
   assign w_partial  = !w_null && !w_complete;
   assign w_same     = (i_in_t == r_snap_t) && (i_in_f == r_snap_f);
   assign w_tmo_hit  = (r_tmo_cnt == TCW'(TMO - 1));

   // Snapshot is complete, so the true rail alone carries the value.
   assign w_mode = r_snap_t[IW-1 -: 2];
   assign w_a    = r_snap_t[3*FW-1 -: FW];
   assign w_b    = r_snap_t[2*FW-1 -: FW];
   assign w_c    = r_snap_t[FW-1:0];
   assign w_m10  = (w_mode == 2'b10);
   assign w_m01  = (w_mode == 2'b01);
   assign w_m11  = (w_mode == 2'b11);

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         if (gi == 0) begin : g_ch0
            assign w_dec_cw_t[0 +: FW] = w_m11 ? w_b : ((w_m10 || w_m01) ? w_a : '0);
            assign w_dec_cw_f[0 +: FW] = w_m11 ? ~w_b : ((w_m10 || w_m01) ? ~w_a : '0);
            assign w_dec_inv_t[0]      = w_m01 || w_m11;
            assign w_dec_inv_f[0]      = w_m10;
         end else begin : g_chn
            localparam bit INV_ONE = (gi == 1);
            assign w_dec_cw_t[gi*FW +: FW] = w_m11 ? w_c : '0;
            assign w_dec_cw_f[gi*FW +: FW] = w_m11 ? ~w_c : '0;
            assign w_dec_inv_t[gi]         = w_m11 && INV_ONE;
            assign w_dec_inv_f[gi]         = w_m11 && !INV_ONE;
         end
      end
   endgenerate

   // A conflicting word freezes the FSM; it is flagged but never sequenced.
   always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      w_settle_inc = 1'b0;
      w_decode     = 1'b0;
      w_release    = 1'b0;
      if (!w_conflict) begin
         case (r_state)
            ST_IDLE: begin
               if (w_complete && !i_out_ack) begin
                  w_state_next = ST_SETTLE;
                  w_capture    = 1'b1;
               end
            end
            ST_SETTLE: begin
               if (!w_same) begin
                  w_state_next = ST_IDLE;
               end else if (r_set_cnt == SCW'(SETTLE - 1)) begin
                  w_state_next = ST_DRIVE;
                  w_decode     = 1'b1;
               end else begin
                  w_settle_inc = 1'b1;
               end
            end
            ST_DRIVE: begin
               if (w_null && (i_out_ack || r_nop)) begin
                  w_state_next = ST_IDLE;
                  w_release    = 1'b1;
               end
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_snap_t       <= '0;
         r_snap_f       <= '0;
         r_set_cnt      <= '0;
         r_tmo_cnt      <= '0;
         r_cw_t         <= '0;
         r_cw_f         <= '0;
         r_inv_t        <= '0;
         r_inv_f        <= '0;
         r_mr_t         <= 1'b0;
         r_mr_f         <= 1'b0;
         r_in_ack       <= 1'b0;
         r_nop          <= 1'b0;
         r_err_conflict <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_capture) begin
            r_snap_t  <= i_in_t;
            r_snap_f  <= i_in_f;
            r_set_cnt <= '0;
         end else if (w_settle_inc) begin
            r_set_cnt <= r_set_cnt + 1'b1;
         end
         if (w_decode) begin
            r_cw_t   <= w_dec_cw_t;
            r_cw_f   <= w_dec_cw_f;
            r_inv_t  <= w_dec_inv_t;
            r_inv_f  <= w_dec_inv_f;
            r_mr_t   <= w_m10;
            r_mr_f   <= w_m01;
            r_in_ack <= 1'b1;
            r_nop    <= (w_mode == 2'b00);
         end else if (w_release) begin
            r_cw_t   <= '0;
            r_cw_f   <= '0;
            r_inv_t  <= '0;
            r_inv_f  <= '0;
            r_mr_t   <= 1'b0;
            r_mr_f   <= 1'b0;
            r_in_ack <= 1'b0;
            r_nop    <= 1'b0;
         end
         if ((r_state == ST_IDLE) && w_partial) begin
            if (!w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end else begin
            r_tmo_cnt <= '0;
         end
         // A new error in the same cycle as the clear pulse survives.
         r_err_conflict <= w_conflict || (r_err_conflict && !i_err_clr);
         r_err_timeout  <= ((r_state == ST_IDLE) && w_partial && w_tmo_hit) ||
                           (r_err_timeout && !i_err_clr);
      end
   end

`ifdef DR_CTRL_STATS_EN
   logic [CW-1:0] r_instr_cnt;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_instr_cnt <= '0;
      end else if (w_decode && (r_instr_cnt != '1)) begin
         r_instr_cnt <= r_instr_cnt + 1'b1;
      end
   end
   assign o_instr_cnt = r_instr_cnt;
`endif

   assign o_in_ack       = r_in_ack;
   assign o_cw_t         = r_cw_t;
   assign o_cw_f         = r_cw_f;
   assign o_inv_t        = r_inv_t;
   assign o_inv_f        = r_inv_f;
   assign o_mr_t         = r_mr_t;
   assign o_mr_f         = r_mr_f;
   assign o_err_conflict = r_err_conflict;
   assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_dr_ctrl_decoder_sync.sv
// Self-checking bench for dr_ctrl_decoder_sync (FW=2, NCH=3, SETTLE=1, TMO=16).
module tb_dr_ctrl_decoder_sync;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_t, in_f;
   logic       in_ack, out_ack, err_clr;
   logic [5:0] cw_t, cw_f;
   logic [2:0] inv_t, inv_f;
   logic       mr_t, mr_f, err_conflict, err_timeout;
`ifdef DR_CTRL_STATS_EN
   logic [15:0] instr_cnt;
`endif

   always #5 clk = ~clk;

   dr_ctrl_decoder_sync #(.FW(2), .NCH(3), .SETTLE(1), .TMO(16), .CW(16)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_t(in_t), .i_in_f(in_f),
      .o_in_ack(in_ack), .i_out_ack(out_ack),
      .o_cw_t(cw_t), .o_cw_f(cw_f), .o_inv_t(inv_t), .o_inv_f(inv_f),
      .o_mr_t(mr_t), .o_mr_f(mr_f),
      .o_err_conflict(err_conflict), .o_err_timeout(err_timeout),
      .i_err_clr(err_clr)
`ifdef DR_CTRL_STATS_EN
      , .o_instr_cnt(instr_cnt)
`endif
   );

   // Expected outputs are written as plain values plus "this field is DATA" masks.
   typedef struct packed {
      logic [7:0] instr;
      logic [5:0] cw_val;
      logic [2:0] ch_mask;
      logic [2:0] inv_val;
      logic [2:0] inv_mask;
      logic       mr_val;
      logic       mr_vld;
   } vec_t;

   typedef struct packed {
      logic [5:0] cw_t, cw_f;
      logic [2:0] inv_t, inv_f;
      logic       mr_t, mr_f;
   } exp_t;

   vec_t vecs[8];
   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;
   int   ndec   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic exp_t to_exp(input vec_t v);
      exp_t       e;
      logic [5:0] m;
      for (int k = 0; k < 3; k++) m[k*2 +: 2] = {2{v.ch_mask[k]}};
      e.cw_t  = v.cw_val & m;
      e.cw_f  = ~v.cw_val & m;
      e.inv_t = v.inv_val & v.inv_mask;
      e.inv_f = ~v.inv_val & v.inv_mask;
      e.mr_t  = v.mr_val & v.mr_vld;
      e.mr_f  = ~v.mr_val & v.mr_vld;
      return e;
   endfunction

   function automatic logic [19:0] outs();
      return {cw_t, cw_f, inv_t, inv_f, mr_t, mr_f};
   endfunction

   task automatic drive_word(input logic [7:0] w);
      in_t = w;
      in_f = ~w;
   endtask

   task automatic drive_null();
      in_t = '0;
      in_f = '0;
   endtask

   task automatic wait_ack(input logic lvl, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((in_ack !== lvl) && (n < 20));
   endtask

   task automatic check_head(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         check(name, outs(), e);
      end
   endtask

   task automatic run_token(input vec_t v, input int idx);
      int   n;
      logic nop;
      nop = (v.instr[7:6] == 2'b00);
      drive_word(v.instr);
      sb_q.push_back(to_exp(v));
      wait_ack(1'b1, n);
      check($sformatf("vec%0d_latency", idx), n, 2);
      check_head($sformatf("vec%0d_out", idx));
      ndec++;
      drive_null();
      if (!nop) begin
         @(negedge clk);
         check($sformatf("vec%0d_hold_ack", idx), in_ack, 1'b1);
         out_ack = 1'b1;
      end
      @(negedge clk);
      check($sformatf("vec%0d_release", idx), {in_ack, outs()}, 21'd0);
      out_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int   n;
      exp_t e;
      vecs[0] = '{8'b10_01_00_00, 6'b00_00_01, 3'b001, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[1] = '{8'b11_00_10_11, 6'b11_11_10, 3'b111, 3'b011, 3'b111, 1'b0, 1'b0};
      vecs[2] = '{8'b01_11_01_10, 6'b00_00_11, 3'b001, 3'b001, 3'b001, 1'b0, 1'b1};
      vecs[3] = '{8'b10_10_11_11, 6'b00_00_10, 3'b001, 3'b000, 3'b001, 1'b1, 1'b1};
      vecs[4] = '{8'b11_01_01_00, 6'b00_00_01, 3'b111, 3'b011, 3'b111, 1'b0, 1'b0};
      vecs[5] = '{8'b00_11_11_11, 6'b00_00_00, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
      vecs[6] = '{8'b01_00_00_00, 6'b00_00_00, 3'b001, 3'b001, 3'b001, 1'b0, 1'b1};
      vecs[7] = '{8'b11_10_00_01, 6'b01_01_00, 3'b111, 3'b011, 3'b111, 1'b0, 1'b0};

      rst_n = 1'b0; out_ack = 1'b0; err_clr = 1'b0;
      drive_null();
      repeat (3) @(negedge clk);
      check("reset_state", {in_ack, outs(), err_conflict, err_timeout}, 23'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_token(vecs[i], i);

      // Input changes during SETTLE: first word dropped, second decoded once.
      drive_word(vecs[0].instr);
      @(negedge clk);
      drive_word(vecs[2].instr);
      @(negedge clk);
      check("restart_no_out", {in_ack, outs()}, 21'd0);
      e = to_exp(vecs[2]);
      sb_q.push_back(e);
      wait_ack(1'b1, n);
      check("restart_latency", n, 2);
      check_head("restart_out");
      ndec++;
      repeat (3) @(negedge clk);
      check("restart_stable", {in_ack, outs()}, {1'b1, e});
      drive_null();
      out_ack = 1'b1;
      @(negedge clk);
      check("restart_release", {in_ack, outs()}, 21'd0);

      // New DATA is blocked while out_ack is still high.
      drive_word(vecs[1].instr);
      repeat (3) @(negedge clk);
      check("ack_block", in_ack, 1'b0);
      out_ack = 1'b0;
      sb_q.push_back(to_exp(vecs[1]));
      wait_ack(1'b1, n);
      check("ack_block_latency", n, 2);
      check_head("ack_block_out");
      ndec++;
      drive_null();
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
      @(negedge clk);

      // Conflict on bit 3.
      in_t = 8'b1001_1000;
      in_f = 8'b0110_1111;
      @(negedge clk);
      check("conflict_set", err_conflict, 1'b1);
      repeat (2) @(negedge clk);
      check("conflict_no_decode", {in_ack, outs()}, 21'd0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("conflict_set_wins", err_conflict, 1'b1);
      drive_null();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("conflict_clr", err_conflict, 1'b0);

      // Timeout: partial word held exactly 15 then 16 cycles.
      in_t = 8'h80; in_f = 8'h00;
      repeat (15) @(negedge clk);
      check("tmo_15", err_timeout, 1'b0);
      @(negedge clk);
      check("tmo_16", err_timeout, 1'b1);
      drive_null();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("tmo_clr", err_timeout, 1'b0);
      for (int r = 0; r < 2; r++) begin
         in_t = 8'h80; in_f = 8'h00;
         repeat (15) @(negedge clk);
         drive_null();
         @(negedge clk);
      end
      check("tmo_null_restart", err_timeout, 1'b0);

      // Reset while driving a token.
      drive_word(vecs[0].instr);
      wait_ack(1'b1, n);
      check("pre_reset_ack", in_ack, 1'b1);
      rst_n = 1'b0;
      drive_null();
      @(negedge clk);
      check("reset_in_drive", {in_ack, outs()}, 21'd0);
      rst_n = 1'b1;
      ndec = 0;
      @(negedge clk);
      run_token(vecs[3], 8);

`ifdef DR_CTRL_STATS_EN
      check("instr_cnt", instr_cnt, ndec);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
